// File: rtl/turbo_pkg.sv
// Shared state encoding, default frame geometry and the direct-form QPP
// interleaver for the turbo encoder frame sequencer.
package turbo_pkg;

  localparam int FRAME_LEN_DEF = 40;
  localparam int QPP_F1_DEF    = 3;
  localparam int QPP_F2_DEF    = 10;
  localparam int TAIL_LEN_DEF  = 3;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    ENCODE = 3'd2,
    TAIL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Closed-form pi(i); the hardware walks the same sequence incrementally.
  function automatic int qpp_pi(input int i,
                                input int k  = FRAME_LEN_DEF,
                                input int f1 = QPP_F1_DEF,
                                input int f2 = QPP_F2_DEF);
    longint acc;
    acc = (longint'(f1) * i + longint'(f2) * i * i) % k;
    return int'(acc);
  endfunction

endpackage

// File: rtl/turbo_enc_ctrl_if.sv
// Bit-source and RSC-facing signals of the turbo encoder frame sequencer.
// master = the sequencer, slave = the bit source plus the two RSC encoders.
interface turbo_enc_ctrl_if;

  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic out_ready;
  logic enc_clr;
  logic enc_en;
  logic enc_mode;
  logic enc1_in;
  logic enc2_in;
  logic sof;
  logic eof;
  logic frame_done;

  modport master (
    input  in_bit, in_valid, out_ready,
    output in_ready, enc_clr, enc_en, enc_mode, enc1_in, enc2_in,
           sof, eof, frame_done
  );

  modport slave (
    output in_bit, in_valid, out_ready,
    input  in_ready, enc_clr, enc_en, enc_mode, enc1_in, enc2_in,
           sof, eof, frame_done
  );

endinterface

// File: rtl/qpp_addr_gen.sv
// Incremental QPP interleaver address: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2,
// all mod K. Both addends stay below K, so one conditional subtract suffices.
module qpp_addr_gen
  import turbo_pkg::*;
#(
  parameter int K  = FRAME_LEN_DEF,
  parameter int F1 = QPP_F1_DEF,
  parameter int F2 = QPP_F2_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 step,
  output logic [$clog2(K)-1:0] pi
);

  localparam int W  = $clog2(K);
  localparam int W1 = W + 1;

  localparam logic [W-1:0] G_INIT = W'((F1 + F2) % K);
  localparam logic [W-1:0] G_STEP = W'((2 * F2) % K);
  localparam logic [W:0]   K_EXT  = W1'(K);

  logic [W-1:0] g;
  logic [W:0]   pi_sum;
  logic [W:0]   g_sum;
  logic [W-1:0] pi_nxt;
  logic [W-1:0] g_nxt;

  always_comb begin
    pi_sum = {1'b0, pi} + {1'b0, g};
    g_sum  = {1'b0, g} + {1'b0, G_STEP};
    pi_nxt = (pi_sum >= K_EXT) ? W'(pi_sum - K_EXT) : pi_sum[W-1:0];
    g_nxt  = (g_sum >= K_EXT) ? W'(g_sum - K_EXT) : g_sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || init) begin
      pi <= '0;
      g  <= G_INIT;
    end else if (step) begin
      pi <= pi_nxt;
      g  <= g_nxt;
    end
  end

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Frame sequencer for the dual-RSC turbo encoder: buffers one frame, then feeds
// RSC #1 in natural order and RSC #2 in QPP order, followed by trellis termination.
//
//   state  | meaning
//   LOAD   | accepting frame bits into the buffer
//   CLEAR  | one-cycle clear of both RSC trellis states
//   ENCODE | data bits to both encoders, advancing on out_ready
//   TAIL   | termination cycles (enc_mode=1), advancing on out_ready
//   DONE   | one-cycle frame_done pulse
module turbo_enc_ctrl
  import turbo_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int QPP_F1    = QPP_F1_DEF,
  parameter int QPP_F2    = QPP_F2_DEF,
  parameter int TAIL_LEN  = TAIL_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  turbo_enc_ctrl_if.master bus
);

  localparam int W  = $clog2(FRAME_LEN);
  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  localparam logic [W-1:0]  LAST_BIT  = W'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(TAIL_LEN - 1);

  state_t               state;
  logic [FRAME_LEN-1:0] frame_buf;
  logic [W-1:0]         wr_cnt;
  logic [W-1:0]         rd_cnt;
  logic [TW-1:0]        tail_cnt;
  logic [W-1:0]         pi;
  logic                 accept;
  logic                 enc_step;
  logic                 tail_step;

  assign accept    = (state == LOAD) && bus.in_valid;
  assign enc_step  = (state == ENCODE) && bus.out_ready;
  assign tail_step = (state == TAIL) && bus.out_ready;

  qpp_addr_gen #(
    .K  (FRAME_LEN),
    .F1 (QPP_F1),
    .F2 (QPP_F2)
  ) u_qpp (
    .clk   (clk),
    .reset (reset),
    .init  (state == CLEAR),
    .step  (enc_step),
    .pi    (pi)
  );

  // Frame storage is never cleared; every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_buf[wr_cnt] <= bus.in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      tail_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (wr_cnt == LAST_BIT) begin
              wr_cnt <= '0;
              state  <= CLEAR;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        CLEAR: begin
          rd_cnt <= '0;
          state  <= ENCODE;
        end
        ENCODE: begin
          if (enc_step) begin
            if (rd_cnt == LAST_BIT) begin
              rd_cnt   <= '0;
              tail_cnt <= '0;
              state    <= TAIL;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          if (tail_step) begin
            if (tail_cnt == LAST_TAIL) begin
              tail_cnt <= '0;
              state    <= DONE;
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= LOAD;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Encoder-side outputs follow out_ready in the same cycle; a stall simply holds the counters.
  assign bus.in_ready   = (state == LOAD);
  assign bus.enc_clr    = (state == CLEAR);
  assign bus.enc_en     = enc_step || tail_step;
  assign bus.enc_mode   = (state == TAIL);
  assign bus.enc1_in    = (state == ENCODE) && frame_buf[rd_cnt];
  assign bus.enc2_in    = (state == ENCODE) && frame_buf[pi];
  assign bus.sof        = enc_step && (rd_cnt == '0);
  assign bus.eof        = tail_step && (tail_cnt == LAST_TAIL);
  assign bus.frame_done = (state == DONE);

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Scoreboard bench for turbo_enc_ctrl: directed frames push expected encoder
// cycles and frame summaries; a negedge monitor pops and compares.
module tb_turbo_enc_ctrl;
  import turbo_pkg::*;

  localparam int K  = FRAME_LEN_DEF;
  localparam int TL = TAIL_LEN_DEF;

  typedef struct {
    logic mode;
    logic b1;
    logic b2;
    logic sof;
    logic eof;
  } cyc_want_t;

  typedef struct {
    int period;
    int onehot;
    int pos2;
  } frame_want_t;

  logic clk = 1'b0;
  logic reset;

  turbo_enc_ctrl_if bus ();

  turbo_enc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  cyc_want_t   want_q[$];
  frame_want_t frm_q[$];

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [K-1:0] bits, input int period,
                            input int onehot, input int pos2);
    cyc_want_t   e;
    frame_want_t f;
    for (int j = 0; j < K; j++) begin
      e.mode = 1'b0;
      e.b1   = bits[j];
      e.b2   = bits[qpp_pi(j)];
      e.sof  = (j == 0);
      e.eof  = 1'b0;
      want_q.push_back(e);
    end
    for (int t = 0; t < TL; t++) begin
      e.mode = 1'b1;
      e.b1   = 1'b0;
      e.b2   = 1'b0;
      e.sof  = 1'b0;
      e.eof  = (t == TL - 1);
      want_q.push_back(e);
    end
    f.period = period;
    f.onehot = onehot;
    f.pos2   = pos2;
    frm_q.push_back(f);
  endtask

  // Returns in the CLEAR cycle when gap==0; gapped loads return one cycle later.
  task automatic load_frame(input logic [K-1:0] bits, input bit gap);
    int budget;
    for (int i = 0; i < K; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      budget = 0;
      while (!bus.in_ready && budget < 200) begin
        tick();
        budget++;
      end
      if (budget >= 200) check("load_in_ready_timeout", 0, 1);
      tick();
      if (gap) begin
        bus.in_valid = 1'b0;
        bus.in_bit   = ~bits[i];
        tick();
      end
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    while (!bus.frame_done && budget < 300) begin
      tick();
      budget++;
    end
    check("frame_done_seen", int'(bus.frame_done), 1);
    tick();
  endtask

  task automatic stall_at(input int n, input int len);
    repeat (n + 1) tick();
    bus.out_ready = 1'b0;
    repeat (len) tick();
    bus.out_ready = 1'b1;
  endtask

  function automatic logic [K-1:0] onehot_bits(input int p);
    logic [K-1:0] b;
    b    = '0;
    b[p] = 1'b1;
    return b;
  endfunction

  // Monitor / scoreboard
  int acc_cnt, start_cyc, last_acc_cyc, clr_cyc, clr_cnt;
  int en0_cnt, en1_cnt, ones1, pos1, ones2, pos2;
  bit in_enc, chk_ready;

  task automatic clear_stats();
    acc_cnt = 0; clr_cnt = 0; en0_cnt = 0; en1_cnt = 0;
    ones1 = 0; pos1 = -1; ones2 = 0; pos2 = -1;
    in_enc = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc_want_t   e;
    frame_want_t f;
    if (chk_ready) begin
      check("in_ready_after_done", int'(bus.in_ready), 1);
      chk_ready = 1'b0;
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      if (acc_cnt == 0) start_cyc = cyc;
      last_acc_cyc = cyc;
      acc_cnt++;
    end
    if (bus.enc_clr === 1'b1) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (in_enc && !bus.out_ready) begin
      check("stall_enc_en", int'(bus.enc_en), 0);
      check("stall_sof", int'(bus.sof), 0);
      check("stall_eof", int'(bus.eof), 0);
      if (want_q.size() > 0) begin
        check("stall_enc1_held", int'(bus.enc1_in), int'(want_q[0].b1));
        check("stall_enc2_held", int'(bus.enc2_in), int'(want_q[0].b2));
        check("stall_enc_mode", int'(bus.enc_mode), int'(want_q[0].mode));
      end
    end
    if (bus.enc_en === 1'b1) begin
      check("enc_clr_during_en", int'(bus.enc_clr), 0);
      if (want_q.size() == 0) begin
        check("unexpected_enc_en", 1, 0);
      end else begin
        e = want_q.pop_front();
        check("enc_mode", int'(bus.enc_mode), int'(e.mode));
        check("enc1_in", int'(bus.enc1_in), int'(e.b1));
        check("enc2_in", int'(bus.enc2_in), int'(e.b2));
        check("sof", int'(bus.sof), int'(e.sof));
        check("eof", int'(bus.eof), int'(e.eof));
        if (e.mode) begin
          en1_cnt++;
        end else begin
          if (bus.enc1_in) begin ones1++; pos1 = en0_cnt; end
          if (bus.enc2_in) begin ones2++; pos2 = en0_cnt; end
          en0_cnt++;
        end
      end
    end
    if (bus.frame_done === 1'b1) begin
      check("done_enc_en", int'(bus.enc_en), 0);
      if (frm_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        f = frm_q.pop_front();
        check("accepted_bits", acc_cnt, K);
        check("clear_cycles", clr_cnt, 1);
        check("clear_after_last_accept", clr_cyc - last_acc_cyc, 1);
        check("encode_cycles", en0_cnt, K);
        check("tail_cycles", en1_cnt, TL);
        check("queue_drained", want_q.size(), 0);
        if (f.period >= 0) check("frame_period", cyc - start_cyc, f.period);
        if (f.onehot >= 0) begin
          check("onehot_enc1_count", ones1, 1);
          check("onehot_enc1_pos", pos1, f.onehot);
          check("onehot_enc2_count", ones2, 1);
          check("onehot_enc2_perm", qpp_pi(pos2), f.onehot);
        end
        if (f.pos2 >= 0) check("onehot_enc2_pos", pos2, f.pos2);
      end
      clear_stats();
      chk_ready = 1'b1;
    end
    if (bus.enc_clr === 1'b1) in_enc = 1'b1;
    if (reset === 1'b1) begin
      clear_stats();
      chk_ready = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [K-1:0] PAT_A = 40'hC35AF0961E;
  localparam logic [K-1:0] PAT_B = 40'h0FF0A55A3C;

  initial begin
    int p2;
    reset         = 1'b1;
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clear_stats();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_enc_clr", int'(bus.enc_clr), 0);
    check("rst_enc_en", int'(bus.enc_en), 0);
    check("rst_enc_mode", int'(bus.enc_mode), 0);
    check("rst_enc1_in", int'(bus.enc1_in), 0);
    check("rst_enc2_in", int'(bus.enc2_in), 0);
    check("rst_sof", int'(bus.sof), 0);
    check("rst_eof", int'(bus.eof), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);

    // one-hot bit 5: enc1 at encode cycle 5, enc2 at 25
    push_frame(onehot_bits(5), 84, 5, 25);
    load_frame(onehot_bits(5), 1'b0);
    wait_done();

    // continuous frames, no stalls
    push_frame(PAT_A, 84, -1, -1);
    load_frame(PAT_A, 1'b0);
    wait_done();
    push_frame(PAT_B, 84, -1, -1);
    load_frame(PAT_B, 1'b0);
    wait_done();

    // stalls: mid-encode, on the first encode cycle, and inside the tail
    push_frame(PAT_A, 87, -1, -1);
    load_frame(PAT_A, 1'b0);
    stall_at(10, 3);
    wait_done();
    push_frame(PAT_B, 86, -1, -1);
    load_frame(PAT_B, 1'b0);
    stall_at(0, 2);
    wait_done();
    push_frame(PAT_A, 86, -1, -1);
    load_frame(PAT_A, 1'b0);
    stall_at(K + 1, 2);
    wait_done();

    // gapped in_valid with garbage on in_bit during the gaps
    push_frame(PAT_B, 123, -1, -1);
    load_frame(PAT_B, 1'b1);
    wait_done();

    // reset at encode cycle 20, then a clean one-hot frame
    push_frame(onehot_bits(5), -1, -1, -1);
    load_frame(onehot_bits(5), 1'b0);
    repeat (21) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_in_ready", int'(bus.in_ready), 1);
    check("midreset_enc_en", int'(bus.enc_en), 0);
    check("midreset_enc_mode", int'(bus.enc_mode), 0);
    want_q.delete();
    frm_q.delete();
    push_frame(onehot_bits(5), 84, 5, 25);
    load_frame(onehot_bits(5), 1'b0);
    wait_done();

    // one-hot sweep: enc2 position must invert the permutation
    for (int p = 0; p < K; p++) begin
      case (p)
        0:       p2 = 0;
        5:       p2 = 25;
        6:       p2 = 2;
        13:      p2 = 1;
        default: p2 = -1;
      endcase
      push_frame(onehot_bits(p), 84, p, p2);
      load_frame(onehot_bits(p), 1'b0);
      wait_done();
    end

    repeat (3) tick();
    check("final_queue_empty", want_q.size(), 0);
    check("final_frames_empty", frm_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
